// File: rtl/op_issuer.sv
// op_issuer: drives the matrix controller's enable/operation/in_data/size inputs for
// each host command, and collects serial-read results into a small output FIFO.
module op_issuer #(
  parameter int MULT_DRAIN = 24,
  parameter int READ_LAT   = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [40:0] cmd,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout,
  output logic        ctl_enable,
  output logic [31:0] ctl_operation,
  output logic [31:0] ctl_in_data,
  output logic [8:0]  ctl_size,
  input  logic [31:0] ctl_out_data,
  output logic        busy,
  output logic        err
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t             r_state;
  logic               r_in_reset;
  logic [8:0]         r_size;
  logic [31:0]        r_op;
  logic [15:0]        r_cnt;
  logic               r_err;
  logic [READ_LAT-1:0] r_pipe;

  logic [31:0]        r_mem [OBUF_DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;

  logic [6:0]         w_c;
  logic [3:0]         w_l;
  logic [15:0]        w_xfer;
  logic [15:0]        w_mult_len;
  logic               w_last_xfer;
  logic               w_last_mult;
  logic [IW-1:0]      w_inflight;
  logic               w_room;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  // Transfer geometry from the latched size: C columns per row, L rows.
  assign w_c         = {1'b0, r_size[5:0]} + 7'd1;
  assign w_l         = {1'b0, r_size[8:6]} + 4'd1;
  assign w_xfer      = 16'(w_c) * 16'(w_l);
  assign w_mult_len  = w_xfer * 16'(w_l) + 16'(MULT_DRAIN);
  assign w_last_xfer = (r_cnt == w_xfer - 16'd1);
  assign w_last_mult = (r_cnt == w_mult_len - 16'd1);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      w_inflight = w_inflight + IW'(r_pipe[i]);
    end
  end

  // Reads in flight already own a buffer slot, so the FIFO can never overflow.
  assign w_room = (16'(r_count) + 16'(w_inflight)) < 16'(OBUF_DEPTH);

  assign w_push     = r_pipe[READ_LAT-1];
  assign w_pop      = dout_valid && dout_ready;
  assign dout_valid = (r_count != '0);
  assign dout       = dout_valid ? r_mem[r_rptr] : '0;
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;

  // Outputs stay at 0 for the cycle after a reset edge, even though IDLE drives enable.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    cmd_ready     = 1'b0;
    din_ready     = 1'b0;
    ctl_enable    = 1'b0;
    ctl_operation = '0;
    ctl_in_data   = '0;
    ctl_size      = '0;
    w_issue       = 1'b0;
    if (!r_in_reset) begin
      case (r_state)
        S_IDLE: begin
          cmd_ready  = 1'b1;
          ctl_enable = 1'b1;
        end
        S_MULT: begin
          ctl_operation = r_op;
          ctl_enable    = 1'b1;
          ctl_size      = r_size;
        end
        S_WRITE: begin
          ctl_operation = r_op;
          ctl_in_data   = din;
          ctl_enable    = din_valid;
          din_ready     = din_valid;
          ctl_size      = r_size;
        end
        S_READ: begin
          ctl_operation = r_op;
          w_issue       = w_room;
          ctl_enable    = w_room;
          ctl_size      = r_size;
        end
        S_DRAIN: begin
          ctl_operation = r_op;
          ctl_size      = r_size;
        end
        S_GAP: begin
          ctl_enable = 1'b1;
          ctl_size   = r_size;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_reset <= 1'b1;
      r_size     <= '0;
      r_op       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values.
      r_in_reset <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            r_size <= cmd[40:32];
            r_op   <= cmd[31:0];
            r_cnt  <= '0;
            case (cmd[3:0])
              4'd1:    r_state <= S_MULT;
              4'd2:    r_state <= S_WRITE;
              4'd3:    r_state <= S_READ;
              default: r_err   <= 1'b1;
            endcase
          end
        end
        S_MULT: begin
          if (w_last_mult) r_state <= S_GAP;
          else             r_cnt   <= r_cnt + 16'd1;
        end
        S_WRITE: begin
          if (din_valid) begin
            if (w_last_xfer) r_state <= S_GAP;
            else             r_cnt   <= r_cnt + 16'd1;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (w_last_xfer) r_state <= S_DRAIN;
            else             r_cnt   <= r_cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          if (w_inflight == '0) r_state <= S_GAP;
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue flags age through the pipe; the tail marks a cycle with valid out_data.
  always_ff @(posedge clk) begin
    if (reset) r_pipe <= '0;
    else       r_pipe <= (r_pipe << 1) | READ_LAT'(w_issue);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= ctl_out_data;
  end

  a_obuf_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == CW'(OBUF_DEPTH))));

endmodule
